cache_access_arbiter: RTL and testbench
=======================================

Name: cache_access_arbiter

Overview:
- Shares the single direct-mapped cache between two requesters (port 0, port 1).
- Sequences each access through lookup, a miss fill from backing memory, a cache write and a response.
- Keeps hit and access statistics.
- Sits between the requesters and the cache/memory datapath. It replaces per-requester sequencing with one arbitrated controller.

Parameters:
ADDR_W, 15, cache address width (tag+index+offset)
CNT_W, 16, width of hit and access statistic counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
req0  in  1  port 0 access request, held until gnt0
addr0  in  ADDR_W  port 0 address, stable while req0 high
req1  in  1  port 1 access request, held until gnt1
addr1  in  ADDR_W  port 1 address, stable while req1 high
gnt0  out  1  port 0 request accepted (1-cycle pulse)
gnt1  out  1  port 1 request accepted (1-cycle pulse)
done0  out  1  port 0 access complete, cache data valid (1-cycle pulse)
done1  out  1  port 1 access complete (1-cycle pulse)
cacheAddr  out  ADDR_W  address driven to cache, registered
hit  in  1  cache hit for cacheAddr, combinational from cache
memRd  out  1  backing-memory block read request
memAck  in  1  memory fill data valid (1-cycle pulse)
wrEn  out  1  cache line write enable
clrStats  in  1  synchronous clear of statistic counters
hitNum  out  CNT_W  hit count
accessNum  out  CNT_W  total access count

Behaviour:
- Reset (rst=0, async): the following all apply.
  - State goes to IDLE.
  - cacheAddr=0, hitNum=0, accessNum=0.
  - All pulse outputs, memRd and wrEn are 0.
  - Round-robin pointer last=1, so port 0 wins the first tie.
  - Reset mid-access abandons the access: no done, memRd drops immediately.
- States: IDLE, LOOKUP, FILL, WRITE, RESP. All outputs are decoded from registered state/owner (Moore).
- IDLE:
  - Neither req -> stay in IDLE.
  - Only one req -> that port becomes owner.
  - Both req -> owner = port != last.
  - On the accepting edge: cacheAddr <= addr of owner; go to LOOKUP.
- LOOKUP:
  - gnt(owner)=1 for this cycle only.
  - accessNum increments.
  - hit=1 -> hitNum increments, go to RESP.
  - hit=0 -> go to FILL.
- FILL:
  - memRd=1 continuously until memAck sampled high.
  - On memAck -> WRITE. No timeout; FILL waits indefinitely.
- WRITE: wrEn=1 for exactly one cycle, cacheAddr unchanged -> RESP.
- RESP: done(owner)=1 for one cycle; last <= owner -> IDLE.
- Latency from accepting edge to done, counted in cycles:
  - Hit: 2.
  - Miss with memAck on the first FILL cycle: 4.
  - Each extra FILL wait cycle adds 1.
- Requesters may drop req after gnt. A req still high in IDLE after done is treated as a new access. The requester must deassert on gnt to avoid a repeat.
- Back-to-back: with both ports requesting continuously, grants alternate 0,1,0,1.
- Ignored inputs:
  - memAck outside FILL.
  - hit outside LOOKUP.
  - req/addr changes while not in IDLE.
- Counters:
  - Saturate at all-ones; no wrap.
  - clrStats=1 zeroes both on the next edge and takes priority over a coincident increment.
  - clrStats never affects the state machine.
- gnt0/gnt1 are mutually exclusive, as are done0/done1. wrEn and memRd are never high in the same cycle.

Test Plan:
- Reset then req0=1, addr0=15'h0123, hit=1 in LOOKUP -> gnt0 pulse at cycle 1, done0 at cycle 2, cacheAddr=0x0123, hitNum=1, accessNum=1, memRd/wrEn never high.
- req1, addr1=15'h7FFF, hit=0, memAck after 3 FILL cycles -> memRd high exactly 3 cycles, wrEn one cycle, done1 at cycle 6, hitNum unchanged, accessNum +1.
- req0 and req1 held high for 4 accesses, hit=1 -> grant order 0,1,0,1, no overlapping gnt/done.
- Preload hitNum/accessNum to 0xFFFE, then 3 hits -> both saturate at 0xFFFF. clrStats asserted in a LOOKUP hit cycle -> both read 0 next cycle.
- Assert rst=0 asynchronously mid-FILL -> memRd, state and counters clear without waiting for clk, no done issued. After release, req0 is served normally.
- memAck pulsed in IDLE and hit toggled in FILL -> no state change and no counter change.

Source files
------------

// File: rtl/cache_access_arbiter.sv
// Arbitrates two requesters onto one direct-mapped cache: lookup, miss fill,
// line write and response, with saturating hit/access statistics.
module cache_access_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [ADDR_W-1:0] cacheAddr,
  input  logic              hit,
  output logic              memRd,
  input  logic              memAck,
  output logic              wrEn,
  input  logic              clrStats,
  output logic [CNT_W-1:0]  hitNum,
  output logic [CNT_W-1:0]  accessNum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              r_state;
  logic                r_owner;
  logic                r_last;
  logic [ADDR_W-1:0]   r_cache_addr;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_done0;
  logic                r_done1;
  logic                r_mem_rd;
  logic                r_wr_en;
  logic [CNT_W-1:0]    r_hit_num;
  logic [CNT_W-1:0]    r_access_num;

  logic                w_any_req;
  logic                w_pick;
  logic                w_lookup;

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign w_any_req = req0 | req1;
  assign w_pick    = req1 & (~req0 | ~r_last);
  assign w_lookup  = (r_state == S_LOOKUP);

  // Sequencer; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_cache_addr <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_wr_en      <= 1'b0;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_mem_rd <= 1'b0;
      r_wr_en  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_pick;
            r_cache_addr <= w_pick ? addr1 : addr0;
            r_gnt0       <= ~w_pick;
            r_gnt1       <= w_pick;
            r_state      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_state <= S_RESP;
          end else begin
            r_mem_rd <= 1'b1;
            r_state  <= S_FILL;
          end
        end
        S_FILL: begin
          if (memAck) begin
            r_wr_en <= 1'b1;
            r_state <= S_WRITE;
          end else begin
            r_mem_rd <= 1'b1;
          end
        end
        S_WRITE: begin
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating statistics; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_num    <= '0;
      r_access_num <= '0;
    end else if (clrStats) begin
      r_hit_num    <= '0;
      r_access_num <= '0;
    end else if (w_lookup) begin
      if (r_access_num != CNT_MAX) begin
        r_access_num <= r_access_num + CNT_W'(1);
      end
      if (hit && (r_hit_num != CNT_MAX)) begin
        r_hit_num <= r_hit_num + CNT_W'(1);
      end
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign cacheAddr = r_cache_addr;
  assign memRd     = r_mem_rd;
  assign wrEn      = r_wr_en;
  assign hitNum    = r_hit_num;
  assign accessNum = r_access_num;

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Bench for cache_access_arbiter: per-access timeline model compared every cycle,
// plus literal latency, ordering, saturation and reset expectations.
module tb_cache_access_arbiter;

  localparam int unsigned ADDR_W = 15;
  // Narrow counters so saturation is reachable in a short run.
  localparam int unsigned CNT_W  = 4;
  localparam int          CMAX   = 15;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    bit                is_hit;
    int                k;
    bit                clr;
  } acc_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic              hit = 1'b0, memAck = 1'b0, clrStats = 1'b0;
  logic              gnt0, gnt1, done0, done1, memRd, wrEn;
  logic [ADDR_W-1:0] cacheAddr;
  logic [CNT_W-1:0]  hitNum, accessNum;

  cache_access_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .cacheAddr(cacheAddr), .hit(hit), .memRd(memRd), .memAck(memAck),
    .wrEn(wrEn), .clrStats(clrStats), .hitNum(hitNum), .accessNum(accessNum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit cmp_en   = 0;
  bit noise    = 0;
  bit clr_now  = 0;

  // Model: pending requests per port, the access in flight and edges since accept.
  acc_t              q0[$], q1[$];
  acc_t              cur;
  bit                m_busy  = 0;
  int                m_phase = 0;
  bit                m_owner = 0;
  bit                m_last  = 1;
  logic [ADDR_W-1:0] m_addr  = '0;
  int                m_hit   = 0;
  int                m_acc   = 0;

  int t_gnt0, t_done0, t_done1, n_memrd, n_wr;
  int gnt_log[$];

  function automatic acc_t mk(input logic [ADDR_W-1:0] a, input bit h, input int k, input bit c);
    acc_t r;
    r.addr = a; r.is_hit = h; r.k = k; r.clr = c;
    return r;
  endfunction

  function automatic int done_ph();
    return cur.is_hit ? 2 : 3 + cur.k;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Model update on each clock edge, and immediately on reset assertion.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_busy = 0; m_phase = 0; m_last = 1; m_addr = '0;
      m_hit = 0; m_acc = 0;
      q0.delete(); q1.delete();
    end else begin
      cyc++;
      if (clrStats) begin
        m_hit = 0; m_acc = 0;
      end else if (m_busy && m_phase == 1) begin
        if (m_acc < CMAX) m_acc++;
        if (hit && m_hit < CMAX) m_hit++;
      end
      if (m_busy) begin
        if (m_phase == done_ph()) begin
          m_busy = 0;
          m_last = m_owner;
        end else begin
          m_phase++;
        end
      end else if (req0 || req1) begin
        m_owner = (req0 && req1) ? !m_last : req1;
        cur     = m_owner ? q1.pop_front() : q0.pop_front();
        m_addr  = cur.addr;
        m_busy  = 1;
        m_phase = 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial forever begin
    bit lk, fl, wr, dn;
    @(negedge clk);
    if (cmp_en) begin
      lk = m_busy && m_phase == 1;
      fl = m_busy && !cur.is_hit && m_phase >= 2 && m_phase <= 1 + cur.k;
      wr = m_busy && !cur.is_hit && m_phase == 2 + cur.k;
      dn = m_busy && m_phase == done_ph();
      chk("gnt0",      int'(gnt0),      int'(lk && !m_owner));
      chk("gnt1",      int'(gnt1),      int'(lk && m_owner));
      chk("done0",     int'(done0),     int'(dn && !m_owner));
      chk("done1",     int'(done1),     int'(dn && m_owner));
      chk("memRd",     int'(memRd),     int'(fl));
      chk("wrEn",      int'(wrEn),      int'(wr));
      chk("cacheAddr", int'(cacheAddr), int'(m_addr));
      chk("hitNum",    int'(hitNum),    m_hit);
      chk("accessNum", int'(accessNum), m_acc);
      if (gnt0) begin gnt_log.push_back(0); t_gnt0 = cyc; end
      if (gnt1) gnt_log.push_back(1);
      if (done0) t_done0 = cyc;
      if (done1) t_done1 = cyc;
      if (memRd) n_memrd++;
      if (wrEn) n_wr++;
    end
  end

  task automatic drive();
    bit in_lk, in_fl;
    req0  = (q0.size() != 0);
    addr0 = req0 ? q0[0].addr : '0;
    req1  = (q1.size() != 0);
    addr1 = req1 ? q1[0].addr : '0;
    in_lk = m_busy && m_phase == 1;
    in_fl = m_busy && !cur.is_hit && m_phase >= 2 && m_phase <= 1 + cur.k;
    hit    = in_lk ? cur.is_hit : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
    memAck = in_fl ? (m_phase == 1 + cur.k) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
    clrStats = clr_now || (in_lk && cur.clr);
  endtask

  // Drive, then advance to just after the next falling edge.
  task automatic step();
    drive();
    @(negedge clk);
    #1;
  endtask

  task automatic run_idle(input string name, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!m_busy && q0.size() == 0 && q1.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk({name, "_completes"}, int'(ok), 1);
  endtask

  task automatic clr_log();
    t_gnt0 = -100; t_done0 = -100; t_done1 = -100;
    n_memrd = 0; n_wr = 0;
    gnt_log.delete();
  endtask

  initial begin
    int t0;
    int exp_ord[4];
    exp_ord = '{0, 1, 0, 1};
    #1 rst = 1'b0;
    #1 cmp_en = 1;
    clr_log();
    @(negedge clk); #1;
    chk("rst_cacheAddr", int'(cacheAddr), 0);
    chk("rst_hitNum",    int'(hitNum),    0);
    chk("rst_accessNum", int'(accessNum), 0);
    chk("rst_memRd",     int'(memRd),     0);
    @(negedge clk); #1;
    rst = 1'b1;
    step();

    // Single hit on port 0.
    clr_log();
    q0.push_back(mk(15'h0123, 1, 0, 0));
    t0 = cyc;
    run_idle("hit0", 20);
    chk("hit0_gnt_lat",  t_gnt0 - t0, 1);
    chk("hit0_done_lat", t_done0 - t0, 2);
    chk("hit0_addr",     int'(cacheAddr), 'h0123);
    chk("hit0_hitNum",   int'(hitNum), 1);
    chk("hit0_accNum",   int'(accessNum), 1);
    chk("hit0_memrd_n",  n_memrd, 0);
    chk("hit0_wr_n",     n_wr, 0);

    // Miss on port 1 with memAck on the third FILL cycle.
    clr_log();
    q1.push_back(mk(15'h7FFF, 0, 3, 0));
    t0 = cyc;
    run_idle("miss1", 30);
    chk("miss1_done_lat", t_done1 - t0, 6);
    chk("miss1_memrd_n",  n_memrd, 3);
    chk("miss1_wr_n",     n_wr, 1);
    chk("miss1_addr",     int'(cacheAddr), 'h7FFF);
    chk("miss1_hitNum",   int'(hitNum), 1);
    chk("miss1_accNum",   int'(accessNum), 2);

    // Both ports held high: grants alternate starting with port 0.
    clr_log();
    q0.push_back(mk(15'h0010, 1, 0, 0));
    q0.push_back(mk(15'h0011, 1, 0, 0));
    q1.push_back(mk(15'h0020, 1, 0, 0));
    q1.push_back(mk(15'h0021, 1, 0, 0));
    run_idle("rr", 40);
    chk("rr_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("rr_order", gnt_log[i], exp_ord[i]);
    chk("rr_hitNum", int'(hitNum), 5);
    chk("rr_accNum", int'(accessNum), 6);

    // Stray memAck in idle, hit toggling during FILL.
    noise = 1;
    repeat (4) step();
    q0.push_back(mk(15'h2AAA, 0, 2, 0));
    run_idle("noise", 30);
    repeat (6) step();
    noise = 0;
    chk("noise_hitNum", int'(hitNum), 5);
    chk("noise_accNum", int'(accessNum), 7);

    // Clear, then drive counters into saturation.
    clr_now = 1;
    step();
    clr_now = 0;
    chk("clr_hitNum", int'(hitNum), 0);
    chk("clr_accNum", int'(accessNum), 0);
    for (int i = 0; i < 14; i++) q0.push_back(mk(ADDR_W'(i), 1, 0, 0));
    run_idle("pre_sat", 100);
    chk("pre_sat_hitNum", int'(hitNum), 14);
    chk("pre_sat_accNum", int'(accessNum), 14);
    for (int i = 0; i < 3; i++) q1.push_back(mk(ADDR_W'(100 + i), 1, 0, 0));
    run_idle("sat", 40);
    chk("sat_hitNum", int'(hitNum), 15);
    chk("sat_accNum", int'(accessNum), 15);
    q0.push_back(mk(15'h0300, 1, 0, 1));
    run_idle("clr_lookup", 20);
    chk("clr_lk_hitNum", int'(hitNum), 0);
    chk("clr_lk_accNum", int'(accessNum), 0);

    // Asynchronous reset in the middle of a fill.
    q0.push_back(mk(15'h0042, 1, 0, 0));
    run_idle("pre_rst", 20);
    clr_log();
    q0.push_back(mk(15'h1234, 0, 20, 0));
    for (int i = 0; i < 20 && !(m_busy && m_phase == 4); i++) step();
    chk("fill_memrd_pre", int'(memRd), 1);
    chk("fill_acc_pre",   int'(accessNum), 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_memRd",     int'(memRd), 0);
    chk("arst_accNum",    int'(accessNum), 0);
    chk("arst_hitNum",    int'(hitNum), 0);
    chk("arst_cacheAddr", int'(cacheAddr), 0);
    @(negedge clk); #1;
    step();
    rst = 1'b1;
    step();
    chk("arst_no_done", t_done0, -100);

    // After reset port 0 wins a tie again and is served normally.
    clr_log();
    q1.push_back(mk(15'h0666, 1, 0, 0));
    q0.push_back(mk(15'h0555, 1, 0, 0));
    t0 = cyc;
    run_idle("post_rst", 30);
    chk("post_rst_first", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
    chk("post_rst_done_lat", t_done0 - t0, 2);
    chk("post_rst_hitNum", int'(hitNum), 2);
    chk("post_rst_accNum", int'(accessNum), 2);
    repeat (2) step();

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
